// File: rtl/ras_ckpt_pkg.sv
// Shared core types for the return address stack: default sizes, index,
// count and PC types, and the per-cycle operation decode.
package ras_ckpt_pkg;

    localparam int RAS_ENTRIES     = 16;
    localparam int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES);
    localparam int PC38_WIDTH      = 38;

    typedef logic [LOG_RAS_ENTRIES-1:0] RAS_idx_t;
    typedef logic [LOG_RAS_ENTRIES:0]   RAS_count_t;
    typedef logic [PC38_WIDTH-1:0]      PC38_t;

    // Exactly one operation is performed per cycle.
    typedef enum logic [2:0] {
        OP_NONE,
        OP_RESTORE,
        OP_REPLACE,
        OP_PUSH,
        OP_POP
    } ras_op_e;

    // Priority: restore > push+pop (replace) > push > pop.
    function automatic ras_op_e ras_decode_op(input logic restore_v,
                                              input logic push_v,
                                              input logic pop_v);
        if (restore_v)           return OP_RESTORE;
        else if (push_v && pop_v) return OP_REPLACE;
        else if (push_v)         return OP_PUSH;
        else if (pop_v)          return OP_POP;
        else                     return OP_NONE;
    endfunction

endpackage

// File: rtl/ras_ckpt.sv
// Checkpointable return address stack. The entry array is a circular
// buffer addressed by the top index; the occupancy count saturates at the
// depth so the oldest entry is silently overwritten on overflow. A restore
// rewinds ptr/count and rewrites the top entry from a checkpoint.
module ras_ckpt #(
    parameter int RAS_ENTRIES = ras_ckpt_pkg::RAS_ENTRIES,
    parameter int PC_WIDTH    = ras_ckpt_pkg::PC38_WIDTH
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             push_valid,
    input  logic [PC_WIDTH-1:0]              push_pc,
    input  logic                             pop_valid,
    input  logic                             restore_valid,
    input  logic [$clog2(RAS_ENTRIES)-1:0]   restore_ptr,
    input  logic [$clog2(RAS_ENTRIES):0]     restore_count,
    input  logic [PC_WIDTH-1:0]              restore_pc,
    output logic [PC_WIDTH-1:0]              top_pc,
    output logic                             top_valid,
    output logic [$clog2(RAS_ENTRIES)-1:0]   ptr,
    output logic [$clog2(RAS_ENTRIES):0]     count,
    output logic                             overflow,
    output logic                             underflow
);

    import ras_ckpt_pkg::*;

    localparam int               IDX_W    = $clog2(RAS_ENTRIES);
    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [PC_WIDTH-1:0] entries_q [RAS_ENTRIES];
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [PC_WIDTH-1:0] wr_data;
    logic [IDX_W-1:0]    ptr_inc;
    logic [IDX_W-1:0]    ptr_dec;
    ras_op_e             op;

    // Index arithmetic wraps naturally at the power-of-two depth.
    assign ptr_inc = ptr_q + 1'b1;
    assign ptr_dec = ptr_q - 1'b1;
    assign op      = ras_decode_op(restore_valid, push_valid, pop_valid);

    // Next-state and single write-port selection for the chosen operation.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        ptr_d       = ptr_q;
        count_d     = count_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = ptr_inc;
        wr_data     = push_pc;

        case (op)
            OP_RESTORE: begin
                ptr_d   = restore_ptr;
                count_d = restore_count;
                wr_en   = (restore_count != '0);
                wr_idx  = restore_ptr;
                wr_data = restore_pc;
            end
            OP_REPLACE: begin
                // Coroutine return: the popped top is replaced in place.
                wr_en   = 1'b1;
                wr_idx  = ptr_q;
                count_d = (count_q == '0) ? CNT_ONE : count_q;
            end
            OP_PUSH: begin
                wr_en  = 1'b1;
                wr_idx = ptr_inc;
                ptr_d  = ptr_inc;
                if (count_q == CNT_FULL) begin
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            OP_POP: begin
                if (count_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    ptr_d   = ptr_dec;
                    count_d = count_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Control state register with synchronous reset overriding all requests.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value regardless of statement order.
        if (RST) begin
            ptr_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry array: one write port, cleared on reset.
    always_ff @(posedge CLK) begin
        // NOTE: the array is reset because top_pc must read 0 after reset;
        // a stack without that need would leave it unreset to save the
        // reset fan-out.
        if (RST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) begin
                entries_q[i] <= '0;
            end
        end else if (wr_en) begin
            entries_q[wr_idx] <= wr_data;
        end
    end

    assign top_pc    = entries_q[ptr_q];
    assign top_valid = (count_q != '0);
    assign ptr       = ptr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    // A checkpoint can never hold more entries than the stack depth.
    ast_restore_count_legal: assert property (
        @(posedge CLK) disable iff (RST)
        restore_valid |-> (restore_count <= CNT_FULL)
    );

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed vector bench for ras_ckpt at depth 4: a table of per-cycle
// requests with hand-computed post-edge outputs, plus a short hand-written
// full-stack sequence.
module tb_ras_ckpt;

    localparam int N  = 4;
    localparam int PW = 38;

    logic          CLK = 1'b0;
    logic          RST;
    logic          push_valid;
    logic [PW-1:0] push_pc;
    logic          pop_valid;
    logic          restore_valid;
    logic [1:0]    restore_ptr;
    logic [2:0]    restore_count;
    logic [PW-1:0] restore_pc;
    logic [PW-1:0] top_pc;
    logic          top_valid;
    logic [1:0]    ptr;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string         name;
        logic          rst;
        logic          push;
        logic [PW-1:0] ppc;
        logic          pop;
        logic          rest;
        logic [1:0]    rptr;
        logic [2:0]    rcnt;
        logic [PW-1:0] rpc;
        logic [PW-1:0] e_top;
        logic          e_tv;
        logic [1:0]    e_ptr;
        logic [2:0]    e_cnt;
        logic          e_ovf;
        logic          e_unf;
    } vec_t;

    vec_t vecs[$];

    ras_ckpt #(.RAS_ENTRIES(N), .PC_WIDTH(PW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .push_valid    (push_valid),
        .push_pc       (push_pc),
        .pop_valid     (pop_valid),
        .restore_valid (restore_valid),
        .restore_ptr   (restore_ptr),
        .restore_count (restore_count),
        .restore_pc    (restore_pc),
        .top_pc        (top_pc),
        .top_valid     (top_valid),
        .ptr           (ptr),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got hang required finish");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] pack(input logic [PW-1:0] t, input logic tv,
                                         input logic [1:0] p, input logic [2:0] c,
                                         input logic ov, input logic un);
        return {18'b0, t, tv, p, c, ov, un};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {top,tv,ptr,cnt,ovf,unf}=%h required %h", name, got, exp);
        end
    endtask

    function automatic void add(input string nm, input logic r, input logic pu,
                                input logic [PW-1:0] ppc, input logic po, input logic rs,
                                input logic [1:0] rptr, input logic [2:0] rcnt,
                                input logic [PW-1:0] rpc, input logic [PW-1:0] et,
                                input logic etv, input logic [1:0] ep, input logic [2:0] ec,
                                input logic eov, input logic eun);
        vec_t v;
        v.name = nm; v.rst = r; v.push = pu; v.ppc = ppc; v.pop = po;
        v.rest = rs; v.rptr = rptr; v.rcnt = rcnt; v.rpc = rpc;
        v.e_top = et; v.e_tv = etv; v.e_ptr = ep; v.e_cnt = ec;
        v.e_ovf = eov; v.e_unf = eun;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic pu, input logic [PW-1:0] ppc,
                         input logic po, input logic rs, input logic [1:0] rptr,
                         input logic [2:0] rcnt, input logic [PW-1:0] rpc);
        RST = r; push_valid = pu; push_pc = ppc; pop_valid = po;
        restore_valid = rs; restore_ptr = rptr; restore_count = rcnt; restore_pc = rpc;
    endtask

    task automatic step_check(input string nm, input logic [PW-1:0] et, input logic etv,
                              input logic [1:0] ep, input logic [2:0] ec,
                              input logic eov, input logic eun);
        @(posedge CLK);
        #1;
        check(nm, pack(top_pc, top_valid, ptr, count, overflow, underflow),
              pack(et, etv, ep, ec, eov, eun));
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);

        //   name          rst push ppc     pop rest rptr rcnt rpc     top     tv ptr cnt ov un
        add("reset",        1, 0, 38'h0,    0, 0, 0, 0, 38'h0,  38'h0,  0, 0, 0, 0, 0);
        // Pop on an empty stack right after reset.
        add("pop_empty",    0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h0,  0, 0, 0, 0, 1);
        add("unf_clears",   0, 0, 38'h0,    0, 0, 0, 0, 38'h0,  38'h0,  0, 0, 0, 0, 0);
        // Basic LIFO order.
        add("push_100",     0, 1, 38'h100,  0, 0, 0, 0, 38'h0,  38'h100,1, 1, 1, 0, 0);
        add("push_200",     0, 1, 38'h200,  0, 0, 0, 0, 38'h0,  38'h200,1, 2, 2, 0, 0);
        add("push_300",     0, 1, 38'h300,  0, 0, 0, 0, 38'h0,  38'h300,1, 3, 3, 0, 0);
        add("pop_a",        0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h200,1, 2, 2, 0, 0);
        add("pop_b",        0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h100,1, 1, 1, 0, 0);
        add("pop_c",        0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h0,  0, 0, 0, 0, 0);
        // Overflow by wrap-around.
        add("push_10",      0, 1, 38'h10,   0, 0, 0, 0, 38'h0,  38'h10, 1, 1, 1, 0, 0);
        add("push_20",      0, 1, 38'h20,   0, 0, 0, 0, 38'h0,  38'h20, 1, 2, 2, 0, 0);
        add("push_30",      0, 1, 38'h30,   0, 0, 0, 0, 38'h0,  38'h30, 1, 3, 3, 0, 0);
        add("push_40",      0, 1, 38'h40,   0, 0, 0, 0, 38'h0,  38'h40, 1, 0, 4, 0, 0);
        add("push_50_ovf",  0, 1, 38'h50,   0, 0, 0, 0, 38'h0,  38'h50, 1, 1, 4, 1, 0);
        add("pop_ov1",      0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h40, 1, 0, 3, 0, 0);
        add("pop_ov2",      0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h30, 1, 3, 2, 0, 0);
        add("pop_ov3",      0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h20, 1, 2, 1, 0, 0);
        add("pop_ov4",      0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h50, 0, 1, 0, 0, 0);
        add("pop_empty2",   0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h50, 0, 1, 0, 0, 1);
        // Replace (push+pop).
        add("reset2",       1, 0, 38'h0,    0, 0, 0, 0, 38'h0,  38'h0,  0, 0, 0, 0, 0);
        add("push_a",       0, 1, 38'hA,    0, 0, 0, 0, 38'h0,  38'hA,  1, 1, 1, 0, 0);
        add("push_b",       0, 1, 38'hB,    0, 0, 0, 0, 38'h0,  38'hB,  1, 2, 2, 0, 0);
        add("replace_c",    0, 1, 38'hC,    1, 0, 0, 0, 38'h0,  38'hC,  1, 2, 2, 0, 0);
        add("pop_to_a",     0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'hA,  1, 1, 1, 0, 0);
        add("pop_to_empty", 0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h0,  0, 0, 0, 0, 0);
        add("replace_empty",0, 1, 38'hD,    1, 0, 0, 0, 38'h0,  38'hD,  1, 0, 1, 0, 0);
        // Checkpoint (ptr=0,count=1,pc=D), speculate, then restore with a push.
        add("spec_push1",   0, 1, 38'h77,   0, 0, 0, 0, 38'h0,  38'h77, 1, 1, 2, 0, 0);
        add("spec_push2",   0, 1, 38'h77,   0, 0, 0, 0, 38'h0,  38'h77, 1, 2, 3, 0, 0);
        add("spec_pop1",    0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h77, 1, 1, 2, 0, 0);
        add("spec_pop2",    0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'hD,  1, 0, 1, 0, 0);
        add("spec_pop3",    0, 0, 38'h0,    1, 0, 0, 0, 38'h0,  38'h0,  0, 3, 0, 0, 0);
        add("restore_push", 0, 1, 38'h99,   0, 1, 0, 1, 38'hD,  38'hD,  1, 0, 1, 0, 0);
        add("restore_pop",  0, 0, 38'h0,    1, 1, 2, 3, 38'h55, 38'h55, 1, 2, 3, 0, 0);
        add("restore_full", 0, 1, 38'h88,   0, 1, 3, 4, 38'h66, 38'h66, 1, 3, 4, 0, 0);
        add("push_full_ovf",0, 1, 38'h1234, 0, 0, 0, 0, 38'h0,  38'h1234,1,0, 4, 1, 0);
        // Restore to empty does not write the entry.
        add("restore_zero", 0, 0, 38'h0,    0, 1, 1, 0, 38'hFF, 38'h77, 0, 1, 0, 0, 0);
        // Reset overrides push and restore mid-sequence.
        add("push_1",       0, 1, 38'h1,    0, 0, 0, 0, 38'h0,  38'h1,  1, 2, 1, 0, 0);
        add("push_2",       0, 1, 38'h2,    0, 0, 0, 0, 38'h0,  38'h2,  1, 3, 2, 0, 0);
        add("push_3",       0, 1, 38'h3,    0, 0, 0, 0, 38'h0,  38'h3,  1, 0, 3, 0, 0);
        add("rst_override", 1, 1, 38'h4,    0, 1, 2, 2, 38'h9,  38'h0,  0, 0, 0, 0, 0);
        add("resume_push",  0, 1, 38'h5,    0, 0, 0, 0, 38'h0,  38'h5,  1, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].push, vecs[i].ppc, vecs[i].pop,
                  vecs[i].rest, vecs[i].rptr, vecs[i].rcnt, vecs[i].rpc);
            step_check(vecs[i].name, vecs[i].e_top, vecs[i].e_tv, vecs[i].e_ptr,
                       vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_unf);
        end

        // Fill to full, overflow once, check the pulse is a single cycle,
        // then replace on a full stack (no overflow, count held).
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 38'(6 + k), 1'b0, 1'b0, '0, '0, '0);
            step_check("fill", 38'(6 + k), 1'b1, 2'(2 + k), 3'(2 + k), 1'b0, 1'b0);
        end
        drive(1'b0, 1'b1, 38'h9, 1'b0, 1'b0, '0, '0, '0);
        step_check("seq_ovf", 38'h9, 1'b1, 2'd1, 3'd4, 1'b1, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        step_check("seq_ovf_drop", 38'h9, 1'b1, 2'd1, 3'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 38'hAB, 1'b1, 1'b0, '0, '0, '0);
        step_check("seq_replace_full", 38'hAB, 1'b1, 2'd1, 3'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0, '0, '0);
        step_check("seq_pop_after", 38'h8, 1'b1, 2'd0, 3'd3, 1'b0, 1'b0);

        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ras_ckpt.md
RAS_CKPT -- requirements
Module: ras_ckpt

Interface
REQ-001 SHALL have parameter RAS_ENTRIES, default 16, meaning stack depth (power of 2, >= 2).
REQ-002 SHALL have parameter PC_WIDTH, default 38, meaning width of a stored return PC.
REQ-003 SHALL have port CLK  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have port push_valid  input  1  meaning push push_pc this cycle.
REQ-006 SHALL have port push_pc  input  PC_WIDTH  meaning return address to push.
REQ-007 SHALL have port pop_valid  input  1  meaning pop the top entry this cycle.
REQ-008 SHALL have port restore_valid  input  1  meaning repair the stack from a checkpoint.
REQ-009 SHALL have port restore_ptr  input  log2(RAS_ENTRIES)  meaning checkpointed top index.
REQ-010 SHALL have port restore_count  input  log2(RAS_ENTRIES)+1  meaning checkpointed occupancy.
REQ-011 SHALL have port restore_pc  input  PC_WIDTH  meaning checkpointed top value.
REQ-012 SHALL have port top_pc  output  PC_WIDTH  meaning current top entry value.
REQ-013 SHALL have port top_valid  output  1  meaning occupancy is nonzero.
REQ-014 SHALL have port ptr  output  log2(RAS_ENTRIES)  meaning current top index, for checkpoint capture.
REQ-015 SHALL have port count  output  log2(RAS_ENTRIES)+1  meaning current occupancy, for checkpoint capture.
REQ-016 SHALL have ports overflow and underflow, each output 1, meaning single-cycle event pulses.

Function
REQ-017 SHALL hold state as an entry array, a top index ptr and an occupancy count; top_pc SHALL be the combinational read of entry[ptr].
REQ-018 SHALL have an update latency of one cycle: a change requested in cycle N is visible on top_pc, ptr and count in cycle N+1.
REQ-019 SHALL treat the highest-priority valid request as the only operation performed each cycle, with priority restore > push+pop > push > pop.
REQ-020 Push only: ptr <= ptr+1 modulo RAS_ENTRIES; entry[ptr+1] <= push_pc; count <= count+1 saturating at RAS_ENTRIES.
REQ-021 Push while count == RAS_ENTRIES: SHALL overwrite the oldest entry through wrap-around, hold count, and pulse overflow high for one cycle.
REQ-022 Pop only with count > 0: ptr <= ptr-1 modulo RAS_ENTRIES; count <= count-1; the entry is not cleared.
REQ-023 Pop only with count == 0: ptr and count hold, and underflow pulses high for one cycle.
REQ-024 Push+pop in the same cycle (coroutine return) SHALL be treated as replace: entry[ptr] <= push_pc, ptr holds, and count <= max(count,1).
REQ-025 Restore: ptr <= restore_ptr and count <= restore_count, and entry[restore_ptr] <= restore_pc when restore_count != 0.
REQ-026 Restore SHALL discard any push or pop in the same cycle and SHALL raise no overflow/underflow pulse.
REQ-027 restore_count > RAS_ENTRIES is illegal input and SHALL be flagged by an assertion in simulation.
REQ-028 overflow and underflow SHALL be registered and SHALL be low in every cycle without their triggering event.

Reset
REQ-029 While RST is high at a clock edge: ptr = 0, count = 0, all entries = 0, overflow = 0, underflow = 0.
REQ-030 The state after reset SHALL give top_pc = 0 and top_valid = 0 in the next cycle.
REQ-031 RST SHALL override all requests in the same cycle, including restore.
REQ-032 Operation SHALL resume normally in the first cycle after RST deasserts.

Structure
REQ-033 The shared core types package SHALL provide RAS_ENTRIES, LOG_RAS_ENTRIES, RAS_idx_t, PC38_t and a new RAS_count_t of width LOG_RAS_ENTRIES+1.
REQ-034 Parameters SHALL default to those package values.
REQ-035 The block SHALL have no sub-module: the entry array is inferred inline as one write port and two read indices (ptr, and ptr+1 for the push write).

Verification (bench with RAS_ENTRIES=4, PC_WIDTH=38)
REQ-036 Push 0x100, 0x200, 0x300, then pop three times -> top_pc sequence 0x300, 0x200, 0x100; top_valid goes low after the third pop.
REQ-037 Push 0x10..0x50 (5 pushes) -> overflow pulses on the 5th push, count stays 4, and four pops yield 0x50, 0x40, 0x30, 0x20.
REQ-038 Pop on empty after reset -> underflow is high for one cycle, ptr = 0, count = 0, and top_pc = 0.
REQ-039 Stack {0xA,0xB}, then push+pop 0xC -> top_pc = 0xC, count = 2, and the next pop gives top_pc = 0xA.
REQ-040 Capture ptr/count/top_pc, push 0x77 twice and pop three times, then restore with the captured values together with a push -> the captured state returns exactly, the push is ignored, and no pulse is raised.
REQ-041 Assert RST mid-sequence with count = 3 and push_valid high -> count = 0 and top_valid = 0 in the next cycle.
